// File: rtl/initiator_cale_de_control.sv
// Host-side start/busy/readyS initiator: operand FIFO, start pulse of START_CYC cycles, result capture.
// op_ready drops while the FIFO is full; `define TIMEOUT_EN adds a sticky abort on stuck WAIT states.
module initiator_cale_de_control #(
  parameter int width     = 8,
  parameter int DEPTH     = 4,
  parameter int START_CYC = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [width-1:0] op_data,
  output logic             start,
  output logic [width-1:0] operand_out,
  input  logic             busy,
  input  logic             readyS,
  input  logic [width-1:0] result_in,
  output logic             res_valid,
  output logic [width-1:0] res_data,
  output logic [7:0]       txn_cnt,
  output logic             timeout_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(START_CYC + 1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if (START_CYC < 2) begin : g_bad_start
    $error("START_CYC must be >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE, START_HI, START_LO, WAIT_BUSY, WAIT_DONE, CAPTURE
  } state_t;

  state_t           state;
  logic [SW-1:0]    st_cnt;
  logic [width-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             push, pop, timeout_hit;

  // A full FIFO refuses the write even when the FSM pops in the same cycle.
  assign op_ready = (count != FULL_CNT);
  assign push     = op_valid & op_ready;
  assign pop      = (state == IDLE) && (count != '0) && readyS;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= op_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      start       <= 1'b0;
      st_cnt      <= '0;
      operand_out <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      txn_cnt     <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            operand_out <= mem[rd_ptr];
            start       <= 1'b1;
            st_cnt      <= SW'(1);
            state       <= START_HI;
          end
        end
        START_HI: begin
          if (st_cnt == SW'(START_CYC)) begin
            start <= 1'b0;
            state <= START_LO;
          end else begin
            st_cnt <= st_cnt + 1'b1;
          end
        end
        START_LO: state <= WAIT_BUSY;
        WAIT_BUSY: begin
          if (busy)             state <= WAIT_DONE;
          else if (timeout_hit) state <= IDLE;
        end
        // busy dominates: readyS alone does not end the transaction
        WAIT_DONE: begin
          if (!busy && readyS)  state <= CAPTURE;
          else if (timeout_hit) state <= IDLE;
        end
        CAPTURE: begin
          res_data  <= result_in;
          res_valid <= 1'b1;
          txn_cnt   <= txn_cnt + 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
  logic          in_wait, leave_wait;

  assign in_wait     = (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign leave_wait  = ((state == WAIT_BUSY) && busy) ||
                       ((state == WAIT_DONE) && !busy && readyS);
  // Hits on the TIMEOUT-th consecutive cycle spent in one WAIT state.
  assign timeout_hit = in_wait && (to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (!in_wait || leave_wait || timeout_hit) to_cnt <= '0;
      else                                       to_cnt <= to_cnt + 1'b1;
      if (timeout_hit && !leave_wait) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
